// File: rtl/udp_rx_demux.sv
// Multi-channel UDP receive demultiplexer: parses the 8-byte UDP header, routes the
// payload to one of CH_N destination-port channels, checks length and counts drops.
module udp_rx_demux #(
    parameter int                  DATA_W    = 16,
    parameter int                  LEN_W     = $clog2(DATA_W/8+1),
    parameter int                  CH_N      = 4,
    parameter logic [CH_N*16-1:0]  DST_PORTS = {16'd18073, 16'd18072, 16'd18071, 16'd18070},
    parameter bit                  MATCH_SRC = 1'b1,
    parameter logic [15:0]         SRC_PORT  = 16'd18070,
    parameter int                  CNT_W     = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              term_i,
    input  logic [LEN_W-1:0]  term_len_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ip_cs_err_i,
    output logic              app_valid_o,
    output logic [CH_N-1:0]   app_ch_o,
    output logic              app_start_o,
    output logic              app_term_o,
    output logic [LEN_W-1:0]  app_term_len_o,
    output logic              app_cancel_o,
    output logic [DATA_W-1:0] app_data_o,
    output logic [LEN_W-1:0]  app_len_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int         HDR_BEATS = 64 / DATA_W;
    localparam logic [1:0] DST_BEAT  = (DATA_W == 16) ? 2'd1 : 2'd0;
    localparam logic [1:0] LAST_BEAT = 2'(HDR_BEATS - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          beat_reg, beat_next;
    logic [47:0]         hdr_reg, hdr_next;
    logic [CH_N-1:0]     ch_sel_reg, ch_sel_next;
    logic                src_ok_reg, src_ok_next;
    logic                started_reg, started_next;
    logic [15:0]         byte_cnt_reg, byte_cnt_next;
    logic [CNT_W-1:0]    drop_cnt_reg;
    logic                drop_evt;

    logic                app_valid_reg, app_valid_next;
    logic [CH_N-1:0]     app_ch_reg, app_ch_next;
    logic                app_start_reg, app_start_next;
    logic                app_term_reg, app_term_next;
    logic [LEN_W-1:0]    app_term_len_reg, app_term_len_next;
    logic                app_cancel_reg, app_cancel_next;
    logic [DATA_W-1:0]   app_data_reg, app_data_next;
    logic [LEN_W-1:0]    app_len_reg, app_len_next;

    logic [1:0]          hb_idx;
    logic [47:0]         hdr_now;
    logic [15:0]         src_now, dst_now, udp_len;
    logic [CH_N-1:0]     hit, match_oh;
    logic                src_ok_now, pass_now;
    logic [15:0]         pay_bytes;
    logic                len_ok;

    // A start beat always becomes header beat 0, whatever the previous packet was doing.
    assign hb_idx = start_i ? 2'd0 : beat_reg;

    // Merge the current beat into the header view; checksum bytes are never stored.
    genvar gi;
    generate
        for (gi = 0; gi < HDR_BEATS; gi++) begin : g_hdr
            localparam int LO = gi * DATA_W;
            localparam int WB = (DATA_W < 48 - LO) ? DATA_W : 48 - LO;
            if (LO < 48) begin : g_w
                assign hdr_now[LO +: WB] = (hb_idx == 2'(gi)) ? data_i[WB-1:0] : hdr_reg[LO +: WB];
            end
        end
        for (gi = 0; gi < CH_N; gi++) begin : g_hit
            assign hit[gi] = (dst_now == DST_PORTS[gi*16 +: 16]);
        end
    endgenerate

    assign src_now    = {hdr_now[7:0], hdr_now[15:8]};
    assign dst_now    = {hdr_now[23:16], hdr_now[31:24]};
    assign udp_len    = {hdr_reg[39:32], hdr_reg[47:40]};
    assign match_oh   = hit & (~hit + CH_N'(1));
    assign src_ok_now = !MATCH_SRC || (src_now == SRC_PORT);
    assign pass_now   = (hb_idx == DST_BEAT) ? ((|match_oh) && src_ok_now)
                                             : ((|ch_sel_reg) && src_ok_reg);
    assign pay_bytes  = byte_cnt_reg + 16'(term_len_i);
    assign len_ok     = (17'(udp_len) == 17'd8 + 17'(pay_bytes));

    always_comb begin
        state_next        = state_reg;
        beat_next         = beat_reg;
        hdr_next          = hdr_reg;
        ch_sel_next       = ch_sel_reg;
        src_ok_next       = src_ok_reg;
        started_next      = started_reg;
        byte_cnt_next     = byte_cnt_reg;
        drop_evt          = 1'b0;
        app_valid_next    = 1'b0;
        app_start_next    = 1'b0;
        app_term_next     = 1'b0;
        app_term_len_next = '0;
        app_cancel_next   = 1'b0;
        app_data_next     = app_data_reg;
        app_len_next      = app_len_reg;
        // Channel stays up through the term/cancel output cycle, then drops.
        app_ch_next       = (app_term_reg || app_cancel_reg) ? '0 : app_ch_reg;

        if (cancel_i) begin
            if (state_reg == PAY)
                app_cancel_next = 1'b1;
            state_next = IDLE;
        end else if (valid_i && (start_i || state_reg == HDR)) begin
            if (start_i && state_reg == PAY && started_reg)
                app_cancel_next = 1'b1;
            hdr_next      = hdr_now;
            started_next  = 1'b0;
            byte_cnt_next = '0;
            if (hb_idx == DST_BEAT) begin
                ch_sel_next = match_oh;
                src_ok_next = src_ok_now;
            end
            if (term_i) begin
                drop_evt   = 1'b1;
                state_next = IDLE;
            end else if (hb_idx == LAST_BEAT) begin
                if (pass_now) begin
                    state_next = PAY;
                end else begin
                    drop_evt   = 1'b1;
                    state_next = DROP;
                end
            end else begin
                state_next = HDR;
                beat_next  = hb_idx + 2'd1;
            end
        end else if (valid_i && state_reg == PAY) begin
            app_valid_next = 1'b1;
            app_start_next = !started_reg;
            app_data_next  = data_i;
            app_len_next   = len_i;
            app_ch_next    = ch_sel_reg;
            started_next   = 1'b1;
            if (term_i) begin
                app_term_next     = 1'b1;
                app_term_len_next = term_len_i;
                app_cancel_next   = !len_ok || ip_cs_err_i;
                state_next        = IDLE;
            end else begin
                byte_cnt_next = byte_cnt_reg + 16'(len_i);
            end
        end else if (valid_i && state_reg == DROP && term_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg        <= IDLE;
            beat_reg         <= '0;
            hdr_reg          <= '0;
            ch_sel_reg       <= '0;
            src_ok_reg       <= 1'b0;
            started_reg      <= 1'b0;
            byte_cnt_reg     <= '0;
            drop_cnt_reg     <= '0;
            app_valid_reg    <= 1'b0;
            app_ch_reg       <= '0;
            app_start_reg    <= 1'b0;
            app_term_reg     <= 1'b0;
            app_term_len_reg <= '0;
            app_cancel_reg   <= 1'b0;
            app_data_reg     <= '0;
            app_len_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            beat_reg         <= beat_next;
            hdr_reg          <= hdr_next;
            ch_sel_reg       <= ch_sel_next;
            src_ok_reg       <= src_ok_next;
            started_reg      <= started_next;
            byte_cnt_reg     <= byte_cnt_next;
            if (drop_evt && drop_cnt_reg != '1)
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            app_valid_reg    <= app_valid_next;
            app_ch_reg       <= app_ch_next;
            app_start_reg    <= app_start_next;
            app_term_reg     <= app_term_next;
            app_term_len_reg <= app_term_len_next;
            app_cancel_reg   <= app_cancel_next;
            app_data_reg     <= app_data_next;
            app_len_reg      <= app_len_next;
        end
    end

    assign app_valid_o    = app_valid_reg;
    assign app_ch_o       = app_ch_reg;
    assign app_start_o    = app_start_reg;
    assign app_term_o     = app_term_reg;
    assign app_term_len_o = app_term_len_reg;
    assign app_cancel_o   = app_cancel_reg;
    assign app_data_o     = app_data_reg;
    assign app_len_o      = app_len_reg;
    assign drop_cnt_o     = drop_cnt_reg;

endmodule
